reset_release_sequencer: RTL and testbench

//  Reset source for the async-reset/async-set flop domains. Reset is asserted asynchronously
//  and released synchronously to clk. Release is staggered across NUM_DOMAINS outputs so that

---
 rtl/rstseq_pkg.sv | 23 ++
 rtl/rstseq_sync.sv | 28 ++
 rtl/reset_release_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_reset_release_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rstseq_pkg.sv
// Shared types and constants for the reset release sequencer.
//   state_t   : sequencer states (ASSERT, HOLD, RELEASE, RUN, SOFT)
//   CAUSE_*   : encodings reported on rst_cause
//   max_int() : elaboration-time helper used to size the cycle counter
package rstseq_pkg;

  typedef enum logic [2:0] {
    ASSERT,
    HOLD,
    RELEASE,
    RUN,
    SOFT
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_POR  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rstseq_sync.sv
// Reset deassertion synchronizer: asserts asynchronously with rst1, releases
// SYNC_STAGES clk edges after rst1 goes high.
//   clk        in  1  clock
//   rst1       in  1  raw reset, asynchronous, active-low
//   rst_sync_n out 1  reset released synchronously to clk (active-low)
module rstseq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst1,
  output logic rst_sync_n
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: flops are always written with non-blocking assignments so every
  // stage samples the value its neighbour held before the edge.
  always_ff @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Reset source for the downstream register domains. Reset asserts
// asynchronously on rst1 and is released synchronously, domain by domain,
// as a thermometer code. A level soft-reset request re-enters the hold and
// release sequence from RUN.
//
// Build option: define RSTSEQ_CAUSE_EN to get a registered rst_cause
// (POR on rst1, SOFT on entry to soft reset); otherwise rst_cause is 2'b00.
//
//   clk           in   1            clock
//   rst1          in   1            reset, asynchronous, active-low
//   soft_rst_req  in   1            level request for soft reset
//   soft_rst_ack  out  1            high while soft reset is accepted and held
//   rst_n_out     out  NUM_DOMAINS  per-domain active-low reset, registered
//   seq_done      out  1            all domains released (RUN)
//   busy          out  1            sequencer not in RUN
//   rst_cause     out  2            last reset cause
module reset_release_sequencer
  import rstseq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_DOMAINS = 3,
  parameter int STAGGER     = 4
) (
  input  logic                   clk,
  input  logic                   rst1,
  input  logic                   soft_rst_req,
  output logic                   soft_rst_ack,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   seq_done,
  output logic                   busy,
  output logic [1:0]             rst_cause
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGGER) + 1);
  localparam int IDX_W = $clog2(NUM_DOMAINS + 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;   // next domain to release
  logic [NUM_DOMAINS-1:0] rst_n_d;
  logic                   rst_sync_n;
  logic                   req_q;

  rstseq_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst1       (rst1),
    .rst_sync_n (rst_sync_n)
  );

  // The request is only sampled here; the FSM looks at it solely in RUN and
  // SOFT, so a request that comes and goes before RUN leaves no trace.
  always_ff @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      req_q <= 1'b0;
    end else begin
      req_q <= soft_rst_req;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_out;

    unique case (state_q)
      ASSERT: begin
        if (rst_sync_n) begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          rst_n_d[0] = 1'b1;
          idx_d      = IDX_W'(1);
          state_d    = (NUM_DOMAINS == 1) ? RUN : RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RELEASE: begin
        if (cnt_q == CNT_W'(STAGGER - 1)) begin
          // Only ever sets a bit, so lower domains stay released.
          for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (idx_q == IDX_W'(k)) begin
              rst_n_d[k] = 1'b1;
            end
          end
          idx_d = idx_q + 1'b1;
          cnt_d = '0;
          if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
            state_d = RUN;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RUN: begin
        if (req_q) begin
          state_d = SOFT;
          rst_n_d = '0;
        end
      end

      SOFT: begin
        if (!req_q) begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d = ASSERT;
        rst_n_d = '0;
      end
    endcase

    // Each state starts counting from zero.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      state_q <= ASSERT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state they describe.
  always_ff @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      rst_n_out <= '0;
    end else begin
      rst_n_out <= rst_n_d;
    end
  end

  always_ff @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      seq_done <= 1'b0;
    end else begin
      seq_done <= (state_d == RUN);
    end
  end

  always_ff @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      busy <= 1'b1;
    end else begin
      busy <= (state_d != RUN);
    end
  end

  always_ff @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      soft_rst_ack <= 1'b0;
    end else begin
      soft_rst_ack <= (state_d == SOFT);
    end
  end

`ifdef RSTSEQ_CAUSE_EN
  always_ff @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      rst_cause <= CAUSE_POR;
    end else if ((state_q == RUN) && (state_d == SOFT)) begin
      rst_cause <= CAUSE_SOFT;
    end
  end
`else
  assign rst_cause = CAUSE_NONE;
`endif

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Self-checking bench for reset_release_sequencer (SYNC_STAGES=2,
// HOLD_CYCLES=16, NUM_DOMAINS=3, STAGGER=4). Directed scenarios followed by
// randomized soft-reset requests and rst1 pulses, all compared every cycle
// against a timestamp-based model of the release schedule.
module tb_reset_release_sequencer;

  localparam int SYNC = 2;
  localparam int HOLD = 16;
  localparam int N    = 3;
  localparam int STG  = 4;

`ifdef RSTSEQ_CAUSE_EN
  localparam bit CAUSE_ON = 1'b1;
`else
  localparam bit CAUSE_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst1;
  logic         soft_rst_req;
  logic         soft_rst_ack;
  logic [N-1:0] rst_n_out;
  logic         seq_done;
  logic         busy;
  logic [1:0]   rst_cause;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reset_release_sequencer #(
    .SYNC_STAGES (SYNC),
    .HOLD_CYCLES (HOLD),
    .NUM_DOMAINS (N),
    .STAGGER     (STG)
  ) dut (
    .clk          (clk),
    .rst1         (rst1),
    .soft_rst_req (soft_rst_req),
    .soft_rst_ack (soft_rst_ack),
    .rst_n_out    (rst_n_out),
    .seq_done     (seq_done),
    .busy         (busy),
    .rst_cause    (rst_cause)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: in reset/sync, sequencing since edge t0, running, soft reset.
  // Released domain count is derived from the edges elapsed since t0.
  typedef enum {M_RST, M_SEQ, M_RUN, M_SOFT} mphase_t;
  mphase_t    ph       = M_RST;
  int         hi_edges = 0;   // edges seen with rst1 high since last reset
  int         t0       = 0;
  int         edge_no  = 0;
  bit         req_m    = 1'b0; // request level as seen one edge ago
  logic [1:0] cause_m  = 2'b01;

  function automatic int rel_count(input int e);
    int c;
    if (e < HOLD) return 0;
    c = 1 + (e - HOLD) / STG;
    return (c > N) ? N : c;
  endfunction

  function automatic logic [N-1:0] therm(input int n);
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic is_thermo(input logic [N-1:0] v);
    logic [N:0] w;
    w = {1'b0, v};
    return ((w & (w + 1'b1)) == '0);
  endfunction

  function automatic logic [1:0] exp_c(input logic [1:0] c);
    return CAUSE_ON ? c : 2'b00;
  endfunction

  function automatic void model_reset();
    ph       = M_RST;
    hi_edges = 0;
    req_m    = 1'b0;
    cause_m  = 2'b01;
  endfunction

  task automatic compare_all(input string pfx);
    logic [N-1:0] exp_rst;
    exp_rst = '0;
    if (ph == M_SEQ) exp_rst = therm(rel_count(edge_no - t0));
    if (ph == M_RUN) exp_rst = '1;
    check({pfx, ":rst_n_out"}, 32'(rst_n_out),    32'(exp_rst));
    check({pfx, ":seq_done"},  32'(seq_done),     32'(ph == M_RUN));
    check({pfx, ":busy"},      32'(busy),         32'(ph != M_RUN));
    check({pfx, ":ack"},       32'(soft_rst_ack), 32'(ph == M_SOFT));
    check({pfx, ":cause"},     32'(rst_cause),    32'(exp_c(cause_m)));
    check({pfx, ":thermo"},    32'(is_thermo(rst_n_out)), 32'd1);
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare 1 time unit after the edge.
  task automatic step(input string pfx);
    bit r1, rq;
    r1 = rst1;
    rq = soft_rst_req;
    @(posedge clk);
    edge_no++;
    if (!r1) begin
      model_reset();
    end else begin
      hi_edges++;
      case (ph)
        M_RST:  if (hi_edges == SYNC + 1) begin ph = M_SEQ; t0 = edge_no; end
        M_SEQ:  if (rel_count(edge_no - t0) == N) ph = M_RUN;
        M_RUN:  if (req_m) begin ph = M_SOFT; cause_m = 2'b10; end
        M_SOFT: if (!req_m) begin ph = M_SEQ; t0 = edge_no; end
        default: ;
      endcase
      req_m = rq;
    end
    #1;
    compare_all(pfx);
  endtask

  task automatic do_async_reset(input string pfx);
    rst1 = 1'b0;
    model_reset();
    #1;
    compare_all(pfx);
  endtask

  // Release rst1 and check the absolute power-on release edges.
  task automatic release_and_check(input string pfx);
    rst1 = 1'b1;
    for (int e = 1; e <= 27; e++) begin
      step(pfx);
      if (e == 18) check({pfx, "_e18"}, 32'(rst_n_out), 32'b000);
      if (e == 19) check({pfx, "_e19"}, 32'(rst_n_out), 32'b001);
      if (e == 22) check({pfx, "_e22"}, 32'(rst_n_out), 32'b001);
      if (e == 23) check({pfx, "_e23"}, 32'(rst_n_out), 32'b011);
      if (e == 26) check({pfx, "_e26_done"}, 32'(seq_done), 32'd0);
      if (e == 27) begin
        check({pfx, "_e27"}, 32'(rst_n_out), 32'b111);
        check({pfx, "_e27_done"}, 32'(seq_done), 32'd1);
      end
    end
  endtask

  task automatic wait_run(input string pfx);
    for (int i = 0; i < 40 && seq_done !== 1'b1; i++) step(pfx);
    check({pfx, "_reached_run"}, 32'(seq_done), 32'd1);
  endtask

  // rst_n_out may only move to zero while rst1 is low.
  always @(rst_n_out) begin
    if (rst1 === 1'b0) check("hold_in_rst", 32'(rst_n_out), 32'd0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit found;
    rst1         = 1'b1;
    soft_rst_req = 1'b0;
    #2;

    // 1. power-on
    do_async_reset("t1_async");
    repeat (5) step("t1_low");
    release_and_check("t1");
    check("t1_cause", 32'(rst_cause), 32'(exp_c(2'b01)));

    // 2. soft reset
    repeat (3) step("t2_run");
    soft_rst_req = 1'b1;
    step("t2_n");
    check("t2_n_done", 32'(seq_done), 32'd1);
    step("t2_n1");
    check("t2_n1_rst", 32'(rst_n_out), 32'd0);
    check("t2_n1_ack", 32'(soft_rst_ack), 32'd1);
    check("t2_cause", 32'(rst_cause), 32'(exp_c(2'b10)));
    repeat (4) step("t2_soft");
    soft_rst_req = 1'b0;
    step("t2_m");
    check("t2_m_ack", 32'(soft_rst_ack), 32'd1);
    for (int e = 1; e <= 17; e++) begin
      step("t2_rel");
      if (e == 1)  check("t2_m1_ack", 32'(soft_rst_ack), 32'd0);
      if (e == 16) check("t2_m16", 32'(rst_n_out), 32'b000);
      if (e == 17) check("t2_m17", 32'(rst_n_out), 32'b001);
    end
    wait_run("t2_wait");

    // 3. reset pulse in mid-sequence
    do_async_reset("t3_pre");
    repeat (2) step("t3_pre_low");
    rst1  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step("t3_seek");
      if (rst_n_out === 3'b011) found = 1'b1;
    end
    check("t3_seek_011", 32'(rst_n_out), 32'b011);
    do_async_reset("t3_async");
    check("t3_async_zero", 32'(rst_n_out), 32'd0);
    repeat (3) step("t3_low");
    release_and_check("t3");

    // 4. request held from power-on
    soft_rst_req = 1'b1;
    do_async_reset("t4_async");
    repeat (3) step("t4_low");
    release_and_check("t4");
    step("t4_e28");
    check("t4_e28_done", 32'(seq_done), 32'd0);
    check("t4_e28_ack", 32'(soft_rst_ack), 32'd1);

    // 5. rst1 falls during SOFT with the request still high
    repeat (2) step("t5_soft");
    do_async_reset("t5_async");
    check("t5_ack", 32'(soft_rst_ack), 32'd0);
    check("t5_rst", 32'(rst_n_out), 32'd0);
    check("t5_cause", 32'(rst_cause), 32'(exp_c(2'b01)));

    // randomized requests and reset pulses
    repeat (2) step("rnd_pre");
    rst1         = 1'b1;
    soft_rst_req = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) soft_rst_req = ~soft_rst_req;
      if ($urandom_range(0, 399) == 0) begin
        do_async_reset("rnd_async");
        repeat ($urandom_range(1, 4)) step("rnd_low");
        rst1 = 1'b1;
      end
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
